// File: rtl/shep_pkg.sv
// Shared definitions for the shep FIFO stream blocks.
// Provides reader FSM state codes, default widths and the occupancy helper.
package shep_pkg;

    localparam int SHEP_WIDTH   = 64;
    localparam int SHEP_CNTBITS = 16;

    localparam logic [1:0] SHEP_RD_IDLE  = 2'd0;
    localparam logic [1:0] SHEP_RD_RUN   = 2'd1;
    localparam logic [1:0] SHEP_RD_DRAIN = 2'd2;
    localparam logic [1:0] SHEP_RD_DONE  = 2'd3;

    typedef enum logic [1:0] {
        RD_IDLE  = SHEP_RD_IDLE,
        RD_RUN   = SHEP_RD_RUN,
        RD_DRAIN = SHEP_RD_DRAIN,
        RD_DONE  = SHEP_RD_DONE
    } shep_rd_state_e;

    // Occupancy after one cycle of push/pop on a 2-entry buffer.
    function automatic logic [1:0] shep_occ_next(
        input logic [1:0] occ,
        input logic       push,
        input logic       pop
    );
        logic [1:0] r;
        r = occ;
        if (push && !pop) begin
            r = occ + 2'd1;
        end else if (pop && !push) begin
            r = occ - 2'd1;
        end
        return r;
    endfunction

endpackage

// File: rtl/shep_skid2.sv
// Two-entry registered stream buffer (circular, head shown combinationally).
// Ports: clk, reset (async high), push/data in, pop, occ (0..2), head word.
module shep_skid2
    import shep_pkg::*;
#(
    parameter int width = SHEP_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [width-1:0] data,
    input  logic             pop,
    output logic [1:0]       occ,
    output logic [width-1:0] head
);

    logic [width-1:0] mem [2];
    logic             wr_ptr;
    logic             rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign pop_ok  = pop && (occ != 2'd0);
    // When full, a push is only taken if a pop frees the head slot,
    // which is the same slot the write pointer targets.
    assign push_ok = push && ((occ != 2'd2) || pop_ok);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            occ    <= 2'd0;
        end else begin
            if (push_ok) begin
                mem[wr_ptr] <= data;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop_ok) begin
                rd_ptr <= ~rd_ptr;
            end
            occ <= shep_occ_next(occ, push_ok, pop_ok);
        end
    end

endmodule

// File: rtl/shep_fifo_reader.sv
// Pops a commanded number of words from a show-ahead FIFO into a stream.
// Ports: start/len command, busy/done status, fifo_* pop side, out_* stream.
module shep_fifo_reader
    import shep_pkg::*;
#(
    parameter int width   = SHEP_WIDTH,
    parameter int cntbits = SHEP_CNTBITS
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [cntbits-1:0] len,
    output logic               busy,
    output logic               done,
    input  logic [width-1:0]   fifo_rd_data,
    input  logic               fifo_empty,
    output logic               fifo_pop,
    output logic [width-1:0]   out_data,
    output logic               out_valid,
    input  logic               out_ready
);

    shep_rd_state_e     state;
    shep_rd_state_e     state_next;
    logic [cntbits-1:0] remaining;
    logic [1:0]         occ;
    logic               hs;
    logic               last_pop;

    assign hs       = out_valid && out_ready;
    assign fifo_pop = (state == RD_RUN) && !fifo_empty
                    && (remaining != '0) && (occ != 2'd2);
    assign last_pop = fifo_pop && (remaining == cntbits'(1));

    assign busy      = (state != RD_IDLE);
    assign done      = (state == RD_DONE);
    assign out_valid = (occ != 2'd0);

    shep_skid2 #(
        .width (width)
    ) u_buf (
        .clk   (clk),
        .reset (reset),
        .push  (fifo_pop),
        .data  (fifo_rd_data),
        .pop   (hs),
        .occ   (occ),
        .head  (out_data)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= RD_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            RD_IDLE: begin
                if (start) begin
                    state_next = (len == '0) ? RD_DONE : RD_RUN;
                end
            end
            RD_RUN: begin
                if (last_pop) begin
                    state_next = RD_DRAIN;
                end
            end
            RD_DRAIN: begin
                // Leave once the buffer empties, counting a draining handshake.
                if ((occ == 2'd0) || ((occ == 2'd1) && hs)) begin
                    state_next = RD_DONE;
                end
            end
            RD_DONE: begin
                state_next = RD_IDLE;
            end
            default: begin
                state_next = RD_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            remaining <= '0;
        end else if ((state == RD_IDLE) && start) begin
            remaining <= len;
        end else if (fifo_pop) begin
            remaining <= remaining - cntbits'(1);
        end
    end

endmodule

// File: tb/tb_shep_fifo_reader.sv
// Directed testbench for shep_fifo_reader.
// Models a show-ahead FIFO and monitors pops, handshakes and done pulses.
module tb_shep_fifo_reader;

    localparam int W  = 64;
    localparam int CB = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [CB-1:0] len;
    logic          busy;
    logic          done;
    logic [W-1:0]  fifo_rd_data;
    logic          fifo_empty;
    logic          fifo_pop;
    logic [W-1:0]  out_data;
    logic          out_valid;
    logic          out_ready;

    int checks = 0;
    int errors = 0;

    logic [W-1:0] fmem [256];
    int fwr = 0;
    int frd = 0;

    int cyc = 0;
    int pop_n = 0;
    int hs_n = 0;
    int done_n = 0;
    int busy_n = 0;
    int done_cyc = 0;
    int mocc = 0;
    int occ_viol = 0;
    int stab_viol = 0;
    int epop_viol = 0;
    int pop_cyc [256];
    int hs_cyc [256];
    logic [W-1:0] rx [256];
    logic prev_stall = 1'b0;
    logic [W-1:0] prev_data = '0;

    always #5 clk = ~clk;

    assign fifo_empty   = (fwr == frd);
    assign fifo_rd_data = fmem[frd[7:0]];

    shep_fifo_reader #(
        .width   (W),
        .cntbits (CB)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .len          (len),
        .busy         (busy),
        .done         (done),
        .fifo_rd_data (fifo_rd_data),
        .fifo_empty   (fifo_empty),
        .fifo_pop     (fifo_pop),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready)
    );

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (reset) begin
            mocc       <= 0;
            prev_stall <= 1'b0;
        end else begin
            if (fifo_pop) begin
                frd <= frd + 1;
                pop_cyc[pop_n[7:0]] <= cyc;
                pop_n <= pop_n + 1;
                if (fifo_empty) epop_viol <= epop_viol + 1;
            end
            if (out_valid && out_ready) begin
                rx[hs_n[7:0]]     <= out_data;
                hs_cyc[hs_n[7:0]] <= cyc;
                hs_n <= hs_n + 1;
            end
            if (done) begin
                done_n   <= done_n + 1;
                done_cyc <= cyc;
            end
            if (busy) busy_n <= busy_n + 1;
            mocc <= mocc + int'(fifo_pop) - int'(out_valid && out_ready);
            if (mocc + int'(fifo_pop) - int'(out_valid && out_ready) > 2)
                occ_viol <= occ_viol + 1;
            if (prev_stall && (out_data !== prev_data))
                stab_viol <= stab_viol + 1;
            prev_stall <= out_valid && !out_ready;
            prev_data  <= out_data;
        end
    end

    task automatic fifo_put(input logic [W-1:0] d);
        fmem[fwr[7:0]] = d;
        fwr = fwr + 1;
    endtask

    task automatic issue(input logic [CB-1:0] n, output int t0);
        start = 1'b1;
        len   = n;
        t0    = cyc;
        @(negedge clk);
        start = 1'b0;
        len   = '0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b0;
        len = '0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++;
            $display("FAIL rst_busy: got %0b expected 0", busy); end
        checks++; if (done !== 1'b0) begin errors++;
            $display("FAIL rst_done: got %0b expected 0", done); end
        checks++; if (fifo_pop !== 1'b0) begin errors++;
            $display("FAIL rst_pop: got %0b expected 0", fifo_pop); end
        checks++; if (out_valid !== 1'b0) begin errors++;
            $display("FAIL rst_valid: got %0b expected 0", out_valid); end
        checks++; if (out_data !== '0) begin errors++;
            $display("FAIL rst_data: got %0h expected 0", out_data); end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        int p0, h0, d0, t0, k;
        p0 = pop_n; h0 = hs_n; d0 = done_n;
        for (int i = 0; i < 8; i++) fifo_put(W'(32'h10 + i));
        out_ready = 1'b1;
        issue(8, t0);
        k = 0;
        while (done_n == d0 && k < 40) begin @(negedge clk); k++; end
        checks++; if (done_n == d0) begin errors++;
            $display("FAIL basic_timeout: got no done expected done"); end
        checks++; if (hs_n - h0 != 8) begin errors++;
            $display("FAIL basic_count: got %0d expected 8", hs_n - h0); end
        for (int i = 0; i < 8; i++) begin
            checks++; if (rx[h0+i] !== W'(32'h10 + i)) begin errors++;
                $display("FAIL basic_data%0d: got %0h expected %0h",
                         i, rx[h0+i], 32'h10 + i); end
            checks++; if (hs_cyc[h0+i] != t0 + 2 + i) begin errors++;
                $display("FAIL basic_hs_cyc%0d: got %0d expected %0d",
                         i, hs_cyc[h0+i], t0 + 2 + i); end
        end
        checks++; if (pop_cyc[p0] != t0 + 1) begin errors++;
            $display("FAIL basic_first_pop: got %0d expected %0d",
                     pop_cyc[p0], t0 + 1); end
        checks++; if (pop_n - p0 != 8) begin errors++;
            $display("FAIL basic_pops: got %0d expected 8", pop_n - p0); end
        checks++; if (done_cyc != t0 + 10) begin errors++;
            $display("FAIL basic_done_cyc: got %0d expected %0d",
                     done_cyc, t0 + 10); end
        checks++; if (busy !== 1'b0) begin errors++;
            $display("FAIL basic_idle: got busy %0b expected 0", busy); end
    endtask

    task automatic test_zero_len();
        int p0, b0, d0, t0;
        p0 = pop_n; b0 = busy_n; d0 = done_n;
        out_ready = 1'b1;
        issue(0, t0);
        checks++; if (done !== 1'b1 || busy !== 1'b1) begin errors++;
            $display("FAIL zero_done: got done %0b busy %0b expected 1 1",
                     done, busy); end
        @(negedge clk);
        checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++;
            $display("FAIL zero_idle: got done %0b busy %0b expected 0 0",
                     done, busy); end
        checks++; if (done_cyc != t0 + 1 || done_n - d0 != 1) begin errors++;
            $display("FAIL zero_done_cyc: got %0d x%0d expected %0d x1",
                     done_cyc, done_n - d0, t0 + 1); end
        checks++; if (pop_n != p0) begin errors++;
            $display("FAIL zero_pops: got %0d expected 0", pop_n - p0); end
        checks++; if (busy_n - b0 != 1) begin errors++;
            $display("FAIL zero_busy: got %0d cycles expected 1", busy_n - b0); end
    endtask

    task automatic test_backpressure();
        int p0, h0, d0, o0, s0, t0, k;
        p0 = pop_n; h0 = hs_n; d0 = done_n; o0 = occ_viol; s0 = stab_viol;
        for (int i = 0; i < 6; i++) fifo_put(W'(32'h20 + i));
        out_ready = 1'b1;
        issue(6, t0);
        k = 0;
        while (done_n == d0 && k < 60) begin
            out_ready = (k % 4 == 0) || (k % 4 == 3);
            @(negedge clk);
            k++;
        end
        out_ready = 1'b1;
        checks++; if (done_n - d0 != 1) begin errors++;
            $display("FAIL bp_done: got %0d expected 1", done_n - d0); end
        checks++; if (hs_n - h0 != 6) begin errors++;
            $display("FAIL bp_count: got %0d expected 6", hs_n - h0); end
        for (int i = 0; i < 6; i++) begin
            checks++; if (rx[h0+i] !== W'(32'h20 + i)) begin errors++;
                $display("FAIL bp_data%0d: got %0h expected %0h",
                         i, rx[h0+i], 32'h20 + i); end
        end
        checks++; if (pop_n - p0 != 6) begin errors++;
            $display("FAIL bp_pops: got %0d expected 6", pop_n - p0); end
        checks++; if (occ_viol != o0) begin errors++;
            $display("FAIL bp_occ: got %0d overflows expected 0", occ_viol - o0); end
        checks++; if (stab_viol != s0) begin errors++;
            $display("FAIL bp_stable: got %0d changes expected 0", stab_viol - s0); end
    endtask

    task automatic test_starved();
        int p0, h0, d0, e0, t0, k, pushed;
        p0 = pop_n; h0 = hs_n; d0 = done_n; e0 = epop_viol;
        pushed = 0;
        out_ready = 1'b1;
        issue(4, t0);
        k = 0;
        while (done_n == d0 && k < 60) begin
            if (k == 3) begin
                checks++; if (pop_n != p0 || busy !== 1'b1) begin errors++;
                    $display("FAIL starve_wait: got pops %0d busy %0b expected 0 1",
                             pop_n - p0, busy); end
            end
            if (k % 5 == 4 && pushed < 4) begin
                fifo_put(W'(32'h40 + pushed));
                pushed++;
            end
            @(negedge clk);
            k++;
        end
        checks++; if (done_n - d0 != 1) begin errors++;
            $display("FAIL starve_done: got %0d expected 1", done_n - d0); end
        checks++; if (epop_viol != e0) begin errors++;
            $display("FAIL starve_empty_pop: got %0d expected 0", epop_viol - e0); end
        checks++; if (hs_n - h0 != 4) begin errors++;
            $display("FAIL starve_count: got %0d expected 4", hs_n - h0); end
        for (int i = 0; i < 4; i++) begin
            checks++; if (rx[h0+i] !== W'(32'h40 + i)) begin errors++;
                $display("FAIL starve_data%0d: got %0h expected %0h",
                         i, rx[h0+i], 32'h40 + i); end
        end
    endtask

    task automatic test_busy_guard();
        int p0, h0, d0, t0, k;
        p0 = pop_n; h0 = hs_n; d0 = done_n;
        for (int i = 0; i < 8; i++) fifo_put(W'(32'h50 + i));
        out_ready = 1'b1;
        issue(5, t0);
        start = 1'b1;
        len = 3;
        @(negedge clk);
        start = 1'b0;
        len = '0;
        k = 0;
        while (done_n == d0 && k < 40) begin @(negedge clk); k++; end
        repeat (6) @(negedge clk);
        checks++; if (pop_n - p0 != 5) begin errors++;
            $display("FAIL guard_pops: got %0d expected 5", pop_n - p0); end
        checks++; if (done_n - d0 != 1) begin errors++;
            $display("FAIL guard_done: got %0d expected 1", done_n - d0); end
        checks++; if (hs_n - h0 != 5) begin errors++;
            $display("FAIL guard_count: got %0d expected 5", hs_n - h0); end
        checks++; if (fwr - frd != 3) begin errors++;
            $display("FAIL guard_left: got %0d expected 3", fwr - frd); end
        checks++; if (rx[h0+4] !== W'(32'h54) || busy !== 1'b0) begin errors++;
            $display("FAIL guard_last: got %0h busy %0b expected 54 0",
                     rx[h0+4], busy); end
        fwr = frd;
    endtask

    task automatic test_async_reset();
        int p0, h0, d0, t0, k;
        p0 = pop_n;
        for (int i = 0; i < 10; i++) fifo_put(W'(32'h60 + i));
        out_ready = 1'b0;
        issue(10, t0);
        repeat (4) @(negedge clk);
        checks++; if (out_valid !== 1'b1 || pop_n - p0 != 2) begin errors++;
            $display("FAIL ar_full: got valid %0b pops %0d expected 1 2",
                     out_valid, pop_n - p0); end
        checks++; if (out_data !== W'(32'h60)) begin errors++;
            $display("FAIL ar_head: got %0h expected 60", out_data); end
        reset = 1'b1;
        #1;
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++;
            $display("FAIL ar_status: got busy %0b done %0b expected 0 0",
                     busy, done); end
        checks++; if (out_valid !== 1'b0 || fifo_pop !== 1'b0) begin errors++;
            $display("FAIL ar_stream: got valid %0b pop %0b expected 0 0",
                     out_valid, fifo_pop); end
        checks++; if (out_data !== '0) begin errors++;
            $display("FAIL ar_data: got %0h expected 0", out_data); end
        @(negedge clk);
        reset = 1'b0;
        fwr = frd;
        p0 = pop_n; h0 = hs_n; d0 = done_n;
        fifo_put(W'(32'h70));
        fifo_put(W'(32'h71));
        out_ready = 1'b1;
        issue(2, t0);
        k = 0;
        while (done_n == d0 && k < 30) begin @(negedge clk); k++; end
        checks++; if (done_n - d0 != 1) begin errors++;
            $display("FAIL ar_done: got %0d expected 1", done_n - d0); end
        checks++; if (hs_n - h0 != 2 || pop_n - p0 != 2) begin errors++;
            $display("FAIL ar_count: got hs %0d pops %0d expected 2 2",
                     hs_n - h0, pop_n - p0); end
        checks++; if (rx[h0] !== W'(32'h70) || rx[h0+1] !== W'(32'h71)) begin
            errors++;
            $display("FAIL ar_after: got %0h %0h expected 70 71",
                     rx[h0], rx[h0+1]); end
        checks++; if (done_cyc != t0 + 4) begin errors++;
            $display("FAIL ar_done_cyc: got %0d expected %0d", done_cyc, t0 + 4); end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) fmem[i] = '0;
        test_reset();
        test_basic();
        test_zero_len();
        test_backpressure();
        test_starved();
        test_busy_guard();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

endmodule
